// File: rtl/dog_extrema_detector.sv
// Scans interior pixels of the middle DoG scale and records strict 3x3x3 extrema
// that clear the contrast threshold into a keypoint BRAM as {x,y}.
module dog_extrema_detector #(
  parameter  int DIMENSION   = 64,
  parameter  int CONTRAST_TH = 8,
  parameter  int MAX_KP      = 256,
  localparam int AW = $clog2(DIMENSION*DIMENSION),
  localparam int KW = $clog2(MAX_KP),
  localparam int CW = $clog2(DIMENSION)
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            start,
  input  logic [8:0]      below_pix,
  input  logic [8:0]      mid_pix,
  input  logic [8:0]      above_pix,
  output logic [AW-1:0]   dog_addr,
  output logic [KW-1:0]   kp_addr,
  output logic [2*CW-1:0] kp_data,
  output logic            kp_wea,
  output logic [KW:0]     kp_count,
  output logic            busy,
  output logic            done,
  output logic            overflow
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t              state, state_next;
  logic                start_q;
  logic [3:0]          k;
  logic [CW-1:0]       x, y;
  logic signed [8:0]   c;
  logic                is_max, is_min;

  logic                start_edge, last_col, last_px;
  logic signed [8:0]   bp, mp, ap, ref_c;
  logic                max_ok, min_ok;
  logic signed [9:0]   c_ext;
  logic [9:0]          c_mag;
  logic                hit, full;
  int                  dx, dy;

  assign start_edge = start & ~start_q;
  assign last_col   = (x == CW'(DIMENSION-2));
  assign last_px    = last_col && (y == CW'(DIMENSION-2));

  // At k=2 the center arrives on mid_pix, so compare against it directly
  // and skip the mid input (it is the center itself).
  always_comb begin
    bp     = $signed(below_pix);
    mp     = $signed(mid_pix);
    ap     = $signed(above_pix);
    ref_c  = (k == 4'd2) ? mp : c;
    max_ok = (bp < ref_c) && (ap < ref_c) && ((k == 4'd2) || (mp < ref_c));
    min_ok = (bp > ref_c) && (ap > ref_c) && ((k == 4'd2) || (mp > ref_c));
  end

  always_comb begin
    c_ext = {c[8], c};
    c_mag = c_ext[9] ? 10'(-c_ext) : 10'(c_ext);
    hit   = (is_max || is_min) && (c_mag >= 10'(CONTRAST_TH));
    full  = (kp_count >= (KW+1)'(MAX_KP));
  end

  always_comb begin
    dx = 0;
    dy = 0;
    case (k)
      4'd1: begin dx = -1; dy = -1; end
      4'd2: begin dx =  0; dy = -1; end
      4'd3: begin dx =  1; dy = -1; end
      4'd4: begin dx = -1; dy =  0; end
      4'd5: begin dx =  1; dy =  0; end
      4'd6: begin dx = -1; dy =  1; end
      4'd7: begin dx =  0; dy =  1; end
      4'd8: begin dx =  1; dy =  1; end
      default: ;
    endcase
    dog_addr = '0;
    if (state == FETCH && k <= 4'd8)
      dog_addr = AW'((int'(y) + dy) * DIMENSION + int'(x) + dx);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_edge) state_next = FETCH;
      FETCH:   if (k == 4'd10) state_next = EVAL;
      EVAL:    state_next = last_px ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == FETCH) || (state == EVAL);
    done    = (state == DONE);
    kp_wea  = (state == EVAL) && hit && !full;
    kp_addr = kp_count[KW-1:0];
    kp_data = kp_wea ? {x, y} : '0;
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      k        <= '0;
      x        <= '0;
      y        <= '0;
      c        <= '0;
      is_max   <= 1'b0;
      is_min   <= 1'b0;
      kp_count <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            kp_count <= '0;
            overflow <= 1'b0;
            x        <= CW'(1);
            y        <= CW'(1);
            k        <= '0;
          end
        end
        FETCH: begin
          k <= k + 4'd1;
          if (k == 4'd2) begin
            c      <= mp;
            is_max <= max_ok;
            is_min <= min_ok;
          end else if (k >= 4'd3) begin
            is_max <= is_max & max_ok;
            is_min <= is_min & min_ok;
          end
        end
        EVAL: begin
          k <= '0;
          if (kp_wea) kp_count <= kp_count + 1'b1;
          if (hit && full) overflow <= 1'b1;
          if (last_col) begin
            x <= CW'(1);
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dog_extrema_detector.sv
// Two detector instances (TH=8/MAX_KP=256 and TH=5/MAX_KP=2) share modelled
// DoG memories; keypoint writes are checked against a queue of expected entries.
module tb_dog_extrema_detector;
  localparam int D = 8;

  typedef struct {int addr; int data;} kp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  always #5 clk = ~clk;

  logic signed [8:0] mem_b [D*D];
  logic signed [8:0] mem_m [D*D];
  logic signed [8:0] mem_a [D*D];

  logic [5:0] addr_a, addr_b;
  logic [7:0] kp_addr_a;
  logic [0:0] kp_addr_b;
  logic [5:0] kp_data_a, kp_data_b;
  logic       kp_wea_a, kp_wea_b;
  logic [8:0] kp_count_a;
  logic [1:0] kp_count_b;
  logic       busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

  logic [8:0] ra_b1, ra_b2, ra_m1, ra_m2, ra_a1, ra_a2;
  logic [8:0] rb_b1, rb_b2, rb_m1, rb_m2, rb_a1, rb_a2;

  // Two-cycle read latency BRAM model per instance
  always @(posedge clk) begin
    ra_b1 <= mem_b[addr_a]; ra_b2 <= ra_b1;
    ra_m1 <= mem_m[addr_a]; ra_m2 <= ra_m1;
    ra_a1 <= mem_a[addr_a]; ra_a2 <= ra_a1;
    rb_b1 <= mem_b[addr_b]; rb_b2 <= rb_b1;
    rb_m1 <= mem_m[addr_b]; rb_m2 <= rb_m1;
    rb_a1 <= mem_a[addr_b]; rb_a2 <= rb_a1;
  end

  dog_extrema_detector #(.DIMENSION(D), .CONTRAST_TH(8), .MAX_KP(256)) dut_a (
    .clk(clk), .rst_in(rst), .start(start),
    .below_pix(ra_b2), .mid_pix(ra_m2), .above_pix(ra_a2),
    .dog_addr(addr_a), .kp_addr(kp_addr_a), .kp_data(kp_data_a), .kp_wea(kp_wea_a),
    .kp_count(kp_count_a), .busy(busy_a), .done(done_a), .overflow(ovf_a));

  dog_extrema_detector #(.DIMENSION(D), .CONTRAST_TH(5), .MAX_KP(2)) dut_b (
    .clk(clk), .rst_in(rst), .start(start),
    .below_pix(rb_b2), .mid_pix(rb_m2), .above_pix(rb_a2),
    .dog_addr(addr_b), .kp_addr(kp_addr_b), .kp_data(kp_data_b), .kp_wea(kp_wea_b),
    .kp_count(kp_count_b), .busy(busy_b), .done(done_b), .overflow(ovf_b));

  int checks = 0, errors = 0;
  kp_t q_a[$], q_b[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int idx(input int x, input int y);
    return y * D + x;
  endfunction

  function automatic kp_t kp(input int addr, input int x, input int y);
    kp_t e;
    e.addr = addr;
    e.data = x * 8 + y;
    return e;
  endfunction

  always @(negedge clk) begin
    kp_t e;
    if (kp_wea_a) begin
      chk("sb_a_pending", int'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("sb_a_addr", int'(kp_addr_a), e.addr);
        chk("sb_a_data", int'(kp_data_a), e.data);
      end
    end
    if (kp_wea_b) begin
      chk("sb_b_pending", int'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("sb_b_addr", int'(kp_addr_b), e.addr);
        chk("sb_b_data", int'(kp_data_b), e.data);
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < D*D; i++) begin
      mem_b[i] = '0;
      mem_m[i] = '0;
      mem_a[i] = '0;
    end
  endtask

  task automatic run_scan(input string tag, input int poke);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy_a && n < 2000) begin
      if (n == poke) start = 1'b1;
      if (n == poke + 3) start = 1'b0;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, n, 432);
    chk({tag, "_done_a"}, int'(done_a), 1);
    chk({tag, "_done_b"}, int'(done_b), 1);
    chk({tag, "_busy_b"}, int'(busy_b), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done_a), 0);
    chk({tag, "_sb_a_left"}, q_a.size(), 0);
    chk({tag, "_sb_b_left"}, q_b.size(), 0);
  endtask

  task automatic chk_end(input string tag, input int ca, input int oa, input int cb, input int ob);
    chk({tag, "_count_a"}, int'(kp_count_a), ca);
    chk({tag, "_ovf_a"}, int'(ovf_a), oa);
    chk({tag, "_count_b"}, int'(kp_count_b), cb);
    chk({tag, "_ovf_b"}, int'(ovf_b), ob);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_wea", int'(kp_wea_a), 0);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_count", int'(kp_count_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All zero: every pixel ties with its neighbours
    run_scan("t1", -1);
    chk_end("t1", 0, 0, 0, 0);

    // Last interior pixel minimum; border pixel never a candidate
    clear_mem();
    mem_m[idx(6,6)] = -9'sd60;
    mem_m[idx(7,7)] = 9'sd90;
    q_a.push_back(kp(0, 6, 6));
    q_b.push_back(kp(0, 6, 6));
    run_scan("t1b", -1);
    chk_end("t1b", 1, 0, 1, 0);

    clear_mem();
    mem_m[idx(3,4)] = 9'sd50;
    q_a.push_back(kp(0, 3, 4));
    q_b.push_back(kp(0, 3, 4));
    run_scan("t2", -1);
    chk_end("t2", 1, 0, 1, 0);

    mem_m[idx(5,2)] = -9'sd50;
    q_a.push_back(kp(0, 5, 2));
    q_a.push_back(kp(1, 3, 4));
    q_b.push_back(kp(0, 5, 2));
    q_b.push_back(kp(1, 3, 4));
    run_scan("t3", -1);
    chk_end("t3", 2, 0, 2, 0);

    mem_a[idx(3,4)] = 9'sd50;
    q_a.push_back(kp(0, 5, 2));
    q_b.push_back(kp(0, 5, 2));
    run_scan("t3b", -1);
    chk_end("t3b", 1, 0, 1, 0);

    // Low contrast: rejected at TH=8, accepted at TH=5
    clear_mem();
    mem_m[idx(3,4)] = 9'sd5;
    q_b.push_back(kp(0, 3, 4));
    run_scan("t4", -1);
    chk_end("t4", 0, 0, 1, 0);

    clear_mem();
    mem_m[idx(2,2)] = 9'sd40;
    mem_m[idx(5,2)] = -9'sd40;
    mem_m[idx(3,5)] = 9'sd40;
    q_a.push_back(kp(0, 2, 2));
    q_a.push_back(kp(1, 5, 2));
    q_a.push_back(kp(2, 3, 5));
    q_b.push_back(kp(0, 2, 2));
    q_b.push_back(kp(1, 5, 2));
    run_scan("t5", -1);
    chk_end("t5", 3, 0, 2, 1);

    // Abort mid-scan after the first keypoint has been written
    clear_mem();
    mem_m[idx(3,4)] = 9'sd50;
    q_a.push_back(kp(0, 3, 4));
    q_b.push_back(kp(0, 3, 4));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    chk("t6_pre_count", int'(kp_count_a), 1);
    chk("t6_pre_busy", int'(busy_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", int'(busy_a), 0);
    chk("t6_rst_done", int'(done_a), 0);
    chk("t6_rst_count", int'(kp_count_a), 0);
    chk("t6_rst_addr", int'(addr_a), 0);
    chk("t6_rst_wea", int'(kp_wea_a), 0);
    chk("t6_rst_count_b", int'(kp_count_b), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_done", int'(done_a), 0);
    chk("t6_idle", int'(busy_a), 0);
    q_a.push_back(kp(0, 3, 4));
    q_b.push_back(kp(0, 3, 4));
    run_scan("t6", 50);
    chk_end("t6", 1, 0, 1, 0);
    repeat (5) @(negedge clk);
    chk("t6_stays_idle", int'(busy_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
